// File: rtl/imem_loader_if.sv
// Loader bus: UART byte stream and flash request in, instruction-memory write port and CPU control out.
// Latency: none (wires only).
// Backpressure: none; rx_valid is a one-cycle strobe and the memory accepts every write.
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  flash;
  logic                  rx_valid;
  logic [7:0]            rx_byte;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]           wr_data;
  logic                  cpu_hold;
  logic [ADDR_WIDTH:0]   words_loaded;
  logic                  overflow;

  // Loader side: consumes the byte stream and drives the memory write port.
  modport master (
    input  flash, rx_valid, rx_byte,
    output wr_en, wr_addr, wr_data, cpu_hold, words_loaded, overflow
  );

  // Environment side: UART receiver, flash switch, instruction memory and CPU.
  modport slave (
    output flash, rx_valid, rx_byte,
    input  wr_en, wr_addr, wr_data, cpu_hold, words_loaded, overflow
  );
endinterface

// File: rtl/imem_loader.sv
// Assembles little-endian UART bytes into 32-bit words and writes them to instruction memory while flash is high.
// Latency: wr_en pulses the cycle after the fourth byte; a byte in the write cycle starts the next word.
// Backpressure: none; bytes beyond capacity are dropped and flagged. IMEM_LOADER_TIMEOUT_EN adds the inter-byte timeout.
module imem_loader #(
  parameter int ADDR_WIDTH     = 10,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input logic           clk,
  input logic           rst,
  imem_loader_if.master bus
);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, FULL} state_t;

  state_t                state, state_nxt;
  logic [1:0]            byte_idx;
  logic [23:0]           byte_buf;   // bytes 0..2 of the word being assembled
  logic [ADDR_WIDTH-1:0] word_addr;  // address the next completed word goes to
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [31:0]           wr_data_q;
  logic [ADDR_WIDTH:0]   words_q;
  logic                  ovf_q;
  logic                  hold_extra; // one extra hold cycle after returning to IDLE

  logic start, take_byte, advance, set_ovf, leave, drop, timeout_hit;

`ifdef IMEM_LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_cnt;

  // Fires on the TIMEOUT_CYCLES-th consecutive byte-less cycle while a word is partly assembled.
  assign timeout_hit = (state == COLLECT) && (byte_idx != 2'd0) && !bus.rx_valid &&
                       (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Idle counter: runs only while a partial word waits in COLLECT.
  always_ff @(posedge clk) begin
    if (rst || state != COLLECT || byte_idx == 2'd0 || bus.rx_valid || timeout_hit)
      idle_cnt <= '0;
    else
      idle_cnt <= idle_cnt + 1'b1;
  end
`else
  // No timeout: a partial word waits indefinitely (expression is constant false).
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

  // State register; reset wins over every input.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and datapath strobes; flash low beats a simultaneous byte.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    take_byte = 1'b0;
    advance   = 1'b0;
    set_ovf   = 1'b0;
    leave     = 1'b0;
    drop      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.flash) begin
          state_nxt = COLLECT;
          start     = 1'b1;
        end
      end
      COLLECT: begin
        if (!bus.flash) begin
          state_nxt = IDLE;
          leave     = 1'b1;
        end else if (bus.rx_valid) begin
          take_byte = 1'b1;
          if (byte_idx == 2'd3) state_nxt = WRITE;
        end else if (timeout_hit) begin
          drop = 1'b1;
        end
      end
      WRITE: begin
        // The write always completes, even if flash has just fallen.
        advance = 1'b1;
        if (!bus.flash) begin
          state_nxt = IDLE;
          leave     = 1'b1;
        end else if (word_addr == {ADDR_WIDTH{1'b1}}) begin
          state_nxt = FULL;
          set_ovf   = bus.rx_valid;
        end else begin
          state_nxt = COLLECT;
          take_byte = bus.rx_valid;
        end
      end
      FULL: begin
        if (!bus.flash) begin
          state_nxt = IDLE;
          leave     = 1'b1;
        end else begin
          set_ovf = bus.rx_valid;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: byte assembly, write-port registers, session counters and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_idx   <= 2'd0;
      byte_buf   <= '0;
      word_addr  <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      words_q    <= '0;
      ovf_q      <= 1'b0;
      hold_extra <= 1'b0;
    end else begin
      if (start) begin
        word_addr <= '0;
        byte_idx  <= 2'd0;
        words_q   <= '0;
        ovf_q     <= 1'b0;
      end
      if (take_byte) begin
        case (byte_idx)
          2'd0: byte_buf[7:0]   <= bus.rx_byte;
          2'd1: byte_buf[15:8]  <= bus.rx_byte;
          2'd2: byte_buf[23:16] <= bus.rx_byte;
          default: begin
            wr_data_q <= {bus.rx_byte, byte_buf};
            wr_addr_q <= word_addr;
          end
        endcase
        byte_idx <= byte_idx + 2'd1;
      end
      if (drop || leave) byte_idx <= 2'd0;
      if (advance) begin
        word_addr <= word_addr + 1'b1;
        words_q   <= words_q + 1'b1;
      end
      if (set_ovf) ovf_q <= 1'b1;
      hold_extra <= leave;
    end
  end

  assign bus.wr_en        = (state == WRITE) && !rst;
  assign bus.wr_addr      = wr_addr_q;
  assign bus.wr_data      = wr_data_q;
  assign bus.cpu_hold     = (state != IDLE) || hold_extra;
  assign bus.words_loaded = words_q;
  assign bus.overflow     = ovf_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed vector table, corner-case sequences and randomized traffic against a byte-stream model.
// Latency: compares outputs at every falling edge.
// Backpressure: not applicable.
module tb_imem_loader;
  localparam int AW  = 2;
  localparam int CAP = 1 << AW;
  localparam int TO  = 8;

  logic clk;
  logic rst;

  imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

  imem_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    else n_pass++;
  endtask

  // Reference model: a session holds a list of received bytes; every fourth byte becomes a pending write.
  bit          m_active, m_full, m_pending, m_tail, m_ovf;
  int          m_words, m_next, m_last_addr, m_idle;
  logic [31:0] m_last_data;
  logic [7:0]  partial[$];

  task automatic model_reset();
    m_active = 0; m_full = 0; m_pending = 0; m_tail = 0; m_ovf = 0;
    m_words = 0; m_next = 0; m_last_addr = 0; m_idle = 0; m_last_data = '0;
    partial.delete();
  endtask

  task automatic model_clock(input logic f, input logic v, input logic [7:0] b, input logic r);
    bit was_pending;
    if (r) begin
      model_reset();
      return;
    end
    m_tail = 0;
    if (!m_active) begin
      if (f) begin
        m_active = 1; m_full = 0; m_next = 0; m_words = 0; m_ovf = 0; m_idle = 0;
        partial.delete();
      end
      return;
    end
    was_pending = m_pending;
    if (m_pending) begin
      m_pending = 0;
      m_words++;
      m_next++;
      if (m_words == CAP) m_full = 1;
    end
    if (!f) begin
      m_active = 0; m_tail = 1; m_full = 0; m_idle = 0;
      partial.delete();
      return;
    end
    if (m_full) begin
      if (v) m_ovf = 1;
      return;
    end
    if (v) begin
      partial.push_back(b);
      m_idle = 0;
      if (partial.size() == 4) begin
        m_last_data = {partial[3], partial[2], partial[1], partial[0]};
        m_last_addr = m_next;
        m_pending = 1;
        partial.delete();
      end
    end
`ifdef IMEM_LOADER_TIMEOUT_EN
    else if (!was_pending && partial.size() != 0) begin
      m_idle++;
      if (m_idle == TO) begin
        partial.delete();
        m_idle = 0;
      end
    end
`else
    else if (was_pending) m_idle = 0;
`endif
  endtask

  logic [31:0] cap_addr[$];
  logic [31:0] cap_data[$];
  logic        cur_rst;

  // Drive one cycle of inputs, then compare the DUT against the model at the falling edge.
  task automatic apply(input logic f, input logic v, input logic [7:0] b, input logic r);
    bus.flash = f; bus.rx_valid = v; bus.rx_byte = b; rst = r; cur_rst = r;
    @(negedge clk);
    chk("wr_en", 32'(bus.wr_en), 32'(m_pending && !cur_rst));
    chk("wr_addr", 32'(bus.wr_addr), 32'(m_last_addr));
    chk("wr_data", bus.wr_data, m_last_data);
    chk("cpu_hold", 32'(bus.cpu_hold), 32'(m_active || m_tail));
    chk("words_loaded", 32'(bus.words_loaded), 32'(m_words));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    if (bus.wr_en === 1'b1) begin
      cap_addr.push_back(32'(bus.wr_addr));
      cap_data.push_back(bus.wr_data);
    end
  endtask

  task automatic clock();
    @(posedge clk);
    model_clock(bus.flash, bus.rx_valid, bus.rx_byte, rst);
    #1;
  endtask

  task automatic run(input logic f, input logic v, input logic [7:0] b, input logic r);
    apply(f, v, b, r);
    clock();
  endtask

  typedef struct {
    logic        f, v;
    logic [7:0]  b;
    logic        en;
    logic [31:0] addr, data;
    logic        hold;
    logic [31:0] words;
    logic        ovf;
  } vec_t;

  function automatic vec_t vec(input logic f, input logic v, input logic [7:0] b, input logic en,
                               input logic [31:0] addr, input logic [31:0] data, input logic hold,
                               input logic [31:0] words, input logic ovf);
    vec_t t;
    t.f = f; t.v = v; t.b = b; t.en = en; t.addr = addr; t.data = data;
    t.hold = hold; t.words = words; t.ovf = ovf;
    return t;
  endfunction

  vec_t tbl[$];

  initial begin
    logic f_rand;
    logic [31:0] exp_w;

    bus.flash = 0; bus.rx_valid = 0; bus.rx_byte = 0; rst = 1; cur_rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_wr_en", 32'(bus.wr_en), 0);
    chk("reset_wr_addr", 32'(bus.wr_addr), 0);
    chk("reset_wr_data", bus.wr_data, 0);
    chk("reset_cpu_hold", 32'(bus.cpu_hold), 0);
    chk("reset_words", 32'(bus.words_loaded), 0);
    chk("reset_overflow", 32'(bus.overflow), 0);
    @(posedge clk);
    model_reset();
    #1;

    // Single word 13 00 50 00, flash drop, then partial word abandoned and a fresh reload.
    tbl.push_back(vec(1, 0, 8'h00, 0, 0, 32'h0, 0, 0, 0));
    tbl.push_back(vec(1, 1, 8'h13, 0, 0, 32'h0, 1, 0, 0));
    tbl.push_back(vec(1, 1, 8'h00, 0, 0, 32'h0, 1, 0, 0));
    tbl.push_back(vec(1, 1, 8'h50, 0, 0, 32'h0, 1, 0, 0));
    tbl.push_back(vec(1, 1, 8'h00, 0, 0, 32'h0, 1, 0, 0));
    tbl.push_back(vec(1, 0, 8'h00, 1, 0, 32'h00500013, 1, 0, 0));
    tbl.push_back(vec(1, 0, 8'h00, 0, 0, 32'h00500013, 1, 1, 0));
    tbl.push_back(vec(0, 0, 8'h00, 0, 0, 32'h00500013, 1, 1, 0));
    tbl.push_back(vec(0, 0, 8'h00, 0, 0, 32'h00500013, 1, 1, 0));
    tbl.push_back(vec(0, 1, 8'h77, 0, 0, 32'h00500013, 0, 1, 0));
    tbl.push_back(vec(1, 0, 8'h00, 0, 0, 32'h00500013, 0, 1, 0));
    tbl.push_back(vec(1, 1, 8'h11, 0, 0, 32'h00500013, 1, 0, 0));
    tbl.push_back(vec(1, 1, 8'h22, 0, 0, 32'h00500013, 1, 0, 0));
    tbl.push_back(vec(0, 1, 8'h33, 0, 0, 32'h00500013, 1, 0, 0));
    tbl.push_back(vec(0, 0, 8'h00, 0, 0, 32'h00500013, 1, 0, 0));
    tbl.push_back(vec(0, 0, 8'h00, 0, 0, 32'h00500013, 0, 0, 0));
    tbl.push_back(vec(1, 0, 8'h00, 0, 0, 32'h00500013, 0, 0, 0));
    tbl.push_back(vec(1, 1, 8'h01, 0, 0, 32'h00500013, 1, 0, 0));
    tbl.push_back(vec(1, 1, 8'h02, 0, 0, 32'h00500013, 1, 0, 0));
    tbl.push_back(vec(1, 1, 8'h03, 0, 0, 32'h00500013, 1, 0, 0));
    tbl.push_back(vec(1, 1, 8'h04, 0, 0, 32'h00500013, 1, 0, 0));
    tbl.push_back(vec(1, 0, 8'h00, 1, 0, 32'h04030201, 1, 0, 0));
    tbl.push_back(vec(1, 0, 8'h00, 0, 0, 32'h04030201, 1, 1, 0));
    foreach (tbl[i]) begin
      apply(tbl[i].f, tbl[i].v, tbl[i].b, 0);
      chk($sformatf("tbl%0d_wr_en", i), 32'(bus.wr_en), 32'(tbl[i].en));
      chk($sformatf("tbl%0d_wr_addr", i), 32'(bus.wr_addr), tbl[i].addr);
      chk($sformatf("tbl%0d_wr_data", i), bus.wr_data, tbl[i].data);
      chk($sformatf("tbl%0d_cpu_hold", i), 32'(bus.cpu_hold), 32'(tbl[i].hold));
      chk($sformatf("tbl%0d_words", i), 32'(bus.words_loaded), tbl[i].words);
      chk($sformatf("tbl%0d_overflow", i), 32'(bus.overflow), 32'(tbl[i].ovf));
      clock();
    end

    // Three words streamed back-to-back: the first byte of words 1 and 2 lands in the write cycle.
    repeat (3) run(0, 0, 0, 0);
    run(1, 0, 0, 0);
    cap_addr.delete(); cap_data.delete();
    for (int n = 0; n < 12; n++) run(1, 1, 8'(8'h10 + n), 0);
    repeat (3) run(1, 0, 0, 0);
    chk("b2b_write_count", cap_addr.size(), 3);
    for (int i = 0; i < 3; i++) begin
      exp_w = {8'(8'h10 + 4*i + 3), 8'(8'h10 + 4*i + 2), 8'(8'h10 + 4*i + 1), 8'(8'h10 + 4*i)};
      if (cap_addr.size() > i) begin
        chk($sformatf("b2b_addr%0d", i), cap_addr[i], 32'(i));
        chk($sformatf("b2b_data%0d", i), cap_data[i], exp_w);
      end
    end
    chk("b2b_words", 32'(bus.words_loaded), 3);

    // Five words into a four-word memory.
    repeat (3) run(0, 0, 0, 0);
    run(1, 0, 0, 0);
    cap_addr.delete(); cap_data.delete();
    for (int n = 0; n < 20; n++) begin
      run(1, 1, 8'($urandom), 0);
      run(1, 0, 0, 0);
    end
    repeat (2) run(1, 0, 0, 0);
    chk("full_write_count", cap_addr.size(), 4);
    for (int i = 0; i < 4; i++)
      if (cap_addr.size() > i) chk($sformatf("full_addr%0d", i), cap_addr[i], 32'(i));
    chk("full_overflow", 32'(bus.overflow), 1);
    chk("full_words", 32'(bus.words_loaded), 4);

    // Reset in the cycle a write is pending.
    repeat (3) run(0, 0, 0, 0);
    run(1, 0, 0, 0);
    run(1, 1, 8'hA1, 0); run(1, 1, 8'hB2, 0); run(1, 1, 8'hC3, 0); run(1, 1, 8'hD4, 0);
    cap_addr.delete(); cap_data.delete();
    apply(1, 0, 0, 1);
    chk("rst_wr_en", 32'(bus.wr_en), 0);
    clock();
    apply(0, 0, 0, 0);
    chk("rst_after_wr_addr", 32'(bus.wr_addr), 0);
    chk("rst_after_wr_data", bus.wr_data, 0);
    chk("rst_after_cpu_hold", 32'(bus.cpu_hold), 0);
    chk("rst_after_words", 32'(bus.words_loaded), 0);
    chk("rst_after_overflow", 32'(bus.overflow), 0);
    chk("rst_no_write", cap_addr.size(), 0);
    clock();

`ifdef IMEM_LOADER_TIMEOUT_EN
    // One stray byte times out; the next four bytes form word 0.
    run(1, 0, 0, 0);
    cap_addr.delete(); cap_data.delete();
    run(1, 1, 8'h55, 0);
    repeat (TO) run(1, 0, 0, 0);
    run(1, 1, 8'hAA, 0); run(1, 1, 8'hBB, 0); run(1, 1, 8'hCC, 0); run(1, 1, 8'hDD, 0);
    repeat (2) run(1, 0, 0, 0);
    chk("timeout_write_count", cap_addr.size(), 1);
    if (cap_addr.size() > 0) begin
      chk("timeout_addr", cap_addr[0], 0);
      chk("timeout_data", cap_data[0], 32'hDDCCBBAA);
    end
    repeat (2) run(0, 0, 0, 0);
`endif

    // Randomized traffic: flash toggles occasionally, bytes arrive on about two thirds of cycles, rare resets.
    f_rand = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 39) == 0) f_rand = ~f_rand;
      run(f_rand, 1'($urandom_range(0, 2) != 0), 8'($urandom),
          1'($urandom_range(0, 299) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
